// File: rtl/issue_buffer.sv
// Decoder-to-backend issue queue: circular FIFO with load-use bubble, stall hold, redirect flush.
// Define ISSUE_BUFFER_BYPASS_EN to let an empty queue pass the input packet straight to out_*.
module issue_buffer #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int UOP_W   = 48
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [4:0]         in_rd,
  input  logic               in_need_to_wb,
  input  logic               in_is_load,
  input  logic [UOP_W-1:0]   in_uop,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic               out_need_to_wb,
  output logic               out_is_load,
  output logic [UOP_W-1:0]   out_uop,
  input  logic               mem_stall,
  input  logic               redirect_valid,
  output logic [63:0]        perf_issue_cnt,
  output logic [31:0]        perf_bubble_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               need_to_wb;
    logic               is_load;
    logic [UOP_W-1:0]   uop;
  } pkt_t;

  pkt_t          mem [DEPTH];
  pkt_t          in_pkt, head, out_pkt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          lu_valid;
  logic [4:0]    lu_rd;
  logic          not_empty, hazard, push, push_wr, issue, fifo_pop, byp_sel, lu_set;

  always_comb begin
    in_pkt = '{pc: in_pc, instr: in_instr, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
               need_to_wb: in_need_to_wb, is_load: in_is_load, uop: in_uop};
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign push      = in_valid & in_ready & ~redirect_valid;

`ifdef ISSUE_BUFFER_BYPASS_EN
  // Selecting on in_valid alone (not on hazard) keeps the hazard check loop-free.
  assign byp_sel   = ~not_empty & in_valid;
`else
  assign byp_sel   = 1'b0;
`endif

  assign out_pkt   = byp_sel ? in_pkt : head;
  assign hazard    = lu_valid & (lu_rd != 5'd0) &
                     ((out_pkt.rs1 == lu_rd) | (out_pkt.rs2 == lu_rd));
  assign out_valid = (not_empty | byp_sel) & ~hazard;
  assign issue     = out_valid & ~mem_stall & ~redirect_valid;
  assign fifo_pop  = issue & ~byp_sel;
  // A bypassed packet that issues immediately never occupies an entry.
  assign push_wr   = push & ~(byp_sel & issue);
  assign lu_set    = issue & out_pkt.is_load & out_pkt.need_to_wb & (out_pkt.rd != 5'd0);

  assign out_pc         = out_pkt.pc;
  assign out_instr      = out_pkt.instr;
  assign out_rs1        = out_pkt.rs1;
  assign out_rs2        = out_pkt.rs2;
  assign out_rd         = out_pkt.rd;
  assign out_need_to_wb = out_pkt.need_to_wb;
  assign out_is_load    = out_pkt.is_load;
  assign out_uop        = out_pkt.uop;

  always_ff @(posedge clock) begin
    if (push_wr) mem[wr_ptr] <= in_pkt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      lu_valid <= 1'b0;
      lu_rd    <= 5'd0;
    end else if (redirect_valid) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      lu_valid <= 1'b0;
    end else begin
      if (push_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_wr, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // lu_valid drops on the load's last mem cycle; a new load issuing then wins.
      if (lu_set) begin
        lu_valid <= 1'b1;
        lu_rd    <= out_pkt.rd;
      end else if (lu_valid && !mem_stall) begin
        lu_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issue_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (issue) perf_issue_cnt <= perf_issue_cnt + 64'd1;
      if (not_empty && hazard && perf_bubble_cnt != '1)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: ordering, stall hold, load-use bubbles, redirect, bypass latency.
module tb_issue_buffer;
`ifdef ISSUE_BUFFER_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_need_to_wb, in_is_load;
  logic [47:0] in_uop;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_need_to_wb, out_is_load;
  logic [47:0] out_uop;
  logic        mem_stall, redirect_valid;
  logic [63:0] perf_issue_cnt;
  logic [31:0] perf_bubble_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  issue_buffer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_need_to_wb(in_need_to_wb),
    .in_is_load(in_is_load), .in_uop(in_uop),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_need_to_wb(out_need_to_wb), .out_is_load(out_is_load), .out_uop(out_uop),
    .mem_stall(mem_stall), .redirect_valid(redirect_valid),
    .perf_issue_cnt(perf_issue_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] d, input logic wb,
                       input logic ld);
    in_valid      = v;
    in_pc         = pc;
    in_instr      = pc[31:0] ^ 32'h0000_0013;
    in_uop        = {16'hA5A5, pc[31:0]};
    in_rs1        = r1;
    in_rs2        = r2;
    in_rd         = d;
    in_need_to_wb = wb;
    in_is_load    = ld;
  endtask

  task automatic idle;
    drive(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_stall = 1'b0; redirect_valid = 1'b0; idle();
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
    total++; if (perf_issue_cnt !== 64'd0) $display("FAIL reset_issue_cnt got %0d want 0", perf_issue_cnt); else passed++;
    total++; if (perf_bubble_cnt !== 32'd0) $display("FAIL reset_bubble_cnt got %0d want 0", perf_bubble_cnt); else passed++;
  endtask

  task automatic test_in_order;
    int n = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, BASE + 64'(4*c), 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      else idle();
      #1;
      if (out_valid && !mem_stall) begin
        total++; if (out_pc !== BASE + 64'(4*n)) $display("FAIL order_pc got %h want %h", out_pc, BASE + 64'(4*n)); else passed++;
        total++; if (out_instr !== (32'(BASE + 64'(4*n)) ^ 32'h13)) $display("FAIL order_instr got %h", out_instr); else passed++;
        total++; if (c !== n + LAT) $display("FAIL order_cycle got %0d want %0d", c, n + LAT); else passed++;
        n++;
      end
      step();
    end
    total++; if (n !== 4) $display("FAIL order_count got %0d want 4", n); else passed++;
    total++; if (perf_issue_cnt !== 64'd4) $display("FAIL order_issue_cnt got %0d want 4", perf_issue_cnt); else passed++;
  endtask

  task automatic test_stall_full;
    int sent = 0;
    int n = 0;
    int bad_head = 0;
    int bad_ready = 0;
    for (int c = 0; c < 20; c++) begin
      mem_stall = (c < 10);
      if (sent < 5) drive(1'b1, BASE + 64'(4*sent), 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
      else idle();
      #1;
      if (c < 10 && in_ready !== (c < 4)) bad_ready++;
      if (c >= 1 && c < 10 && (out_valid !== 1'b1 || out_pc !== BASE)) bad_head++;
      if (c >= 10 && out_valid) begin
        total++; if (out_pc !== BASE + 64'(4*n)) $display("FAIL drain_pc got %h want %h", out_pc, BASE + 64'(4*n)); else passed++;
        n++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    total++; if (bad_ready !== 0) $display("FAIL stall_in_ready bad cycles %0d want 0", bad_ready); else passed++;
    total++; if (bad_head !== 0) $display("FAIL stall_head bad cycles %0d want 0", bad_head); else passed++;
    total++; if (n !== 5) $display("FAIL drain_count got %0d want 5", n); else passed++;
    total++; if (perf_issue_cnt !== 64'd9) $display("FAIL drain_issue_cnt got %0d want 9", perf_issue_cnt); else passed++;
  endtask

  // Load then dependent, both queued under stall; S stall cycles follow the load's issue.
  task automatic run_ld(input logic [4:0] ld_rd, input logic [4:0] r1, input logic [4:0] r2,
                        input int s, input int exp_c, input logic [31:0] exp_bub);
    bit done = 0;
    mem_stall = 1'b1;
    drive(1'b1, 64'h8000_0200, 5'd0, 5'd0, ld_rd, 1'b1, 1'b1);
    #1; step();
    drive(1'b1, 64'h8000_0204, r1, r2, 5'd3, 1'b1, 1'b0);
    #1; step();
    mem_stall = 1'b0; idle();
    #1;
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0200) $display("FAIL ld_issue valid %0b pc %h want 1 80000200", out_valid, out_pc); else passed++;
    step();
    for (int c = 3; c < 13; c++) begin
      mem_stall = (c < 3 + s);
      #1;
      if (!done && out_valid && !mem_stall) begin
        total++; if (c !== exp_c) $display("FAIL dep_cycle got %0d want %0d", c, exp_c); else passed++;
        total++; if (out_pc !== 64'h8000_0204) $display("FAIL dep_pc got %h want 80000204", out_pc); else passed++;
        done = 1;
      end
      step();
    end
    mem_stall = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL dep_timeout got %0b want 1", done); else passed++;
    total++; if (perf_bubble_cnt !== exp_bub) $display("FAIL bubble_cnt got %0d want %0d", perf_bubble_cnt, exp_bub); else passed++;
  endtask

  task automatic test_load_use;
    run_ld(5'd5, 5'd5, 5'd0, 0, 4, 32'd1);
    run_ld(5'd0, 5'd0, 5'd0, 0, 3, 32'd1);
  endtask

  task automatic test_load_stall;
    run_ld(5'd7, 5'd0, 5'd7, 3, 7, 32'd5);
    total++; if (perf_issue_cnt !== 64'd15) $display("FAIL ld_issue_cnt got %0d want 15", perf_issue_cnt); else passed++;
  endtask

  task automatic test_redirect;
    int seen = 0;
    mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 64'h8000_0300 + 64'(4*c), 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
      #1; step();
    end
    mem_stall = 1'b0; redirect_valid = 1'b1;
    drive(1'b1, 64'h8000_03F0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    #1; step();
    redirect_valid = 1'b0; idle();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL redir_out_valid got %0b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL redir_in_ready got %0b want 1", in_ready); else passed++;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      step();
    end
    total++; if (seen !== 0) $display("FAIL redir_ghost got %0d want 0", seen); else passed++;
    total++; if (perf_issue_cnt !== 64'd15) $display("FAIL redir_issue_cnt got %0d want 15", perf_issue_cnt); else passed++;
  endtask

  task automatic test_bypass;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 64'h8000_0100, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
      else idle();
      #1;
      total++; if (out_valid !== (c == LAT)) $display("FAIL byp_valid c%0d got %0b want %0b", c, out_valid, c == LAT); else passed++;
      if (c == LAT) begin
        total++; if (out_pc !== 64'h8000_0100) $display("FAIL byp_pc got %h want 80000100", out_pc); else passed++;
      end
      step();
    end
    total++; if (perf_issue_cnt !== 64'd16) $display("FAIL byp_issue_cnt got %0d want 16", perf_issue_cnt); else passed++;
  endtask

  task automatic test_reset_mid;
    mem_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 64'h8000_0400 + 64'(4*c), 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      #1; step();
    end
    idle(); reset = 1'b1;
    step();
    reset = 1'b0; mem_stall = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %0b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %0b want 1", in_ready); else passed++;
    total++; if (perf_issue_cnt !== 64'd0 || perf_bubble_cnt !== 32'd0)
      $display("FAIL rst_mid_perf got %0d/%0d want 0/0", perf_issue_cnt, perf_bubble_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_stall_full();
    test_load_use();
    test_load_stall();
    test_redirect();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- Decoupling queue between the decoder and the backend execute/mem stage.
- Buffers decoded instruction packets in a small circular FIFO and presents the head to the backend.
- Holds the head while the backend raises mem_stall, and inserts a load-use bubble.
- Flushes all entries on a backend redirect and keeps issue/bubble perf counters.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2.
- PC_W, 64, PC width.
- INSTR_W, 32, instruction width.
- UOP_W, 48, packed remaining decoded fields (src/imm select, types, ls_size, flags), carried opaquely.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoder packet valid
- in_ready  out  1  buffer can accept a packet
- in_pc  in  PC_W  packet PC
- in_instr  in  INSTR_W  raw instruction
- in_rs1  in  5  source reg 1
- in_rs2  in  5  source reg 2
- in_rd  in  5  destination reg
- in_need_to_wb  in  1  writes rd
- in_is_load  in  1  load instruction
- in_uop  in  UOP_W  other decoded fields
- out_valid  out  1  head presented to backend (instr_valid)
- out_pc  out  PC_W  head PC
- out_instr  out  INSTR_W  head instruction
- out_rs1  out  5  head rs1
- out_rs2  out  5  head rs2
- out_rd  out  5  head rd
- out_need_to_wb  out  1  head writes rd
- out_is_load  out  1  head is load
- out_uop  out  UOP_W  head fields
- mem_stall  in  1  backend stall; head must stay stable
- redirect_valid  in  1  backend redirect, flush
- perf_issue_cnt  out  64  packets issued
- perf_bubble_cnt  out  32  load-use bubble cycles, saturating

Behaviour:
- Clock and reset: single clock `clock`. `reset` is synchronous, active-high.
- Reset values: count=0, rd/wr pointers=0, lu_valid=0, lu_rd=0, both perf counters=0, out_valid=0, in_ready=1.
- Storage: circular FIFO with log2(DEPTH) pointers that wrap naturally. Count runs 0..DEPTH.
- in_ready = (count != DEPTH). It depends on state only, with no same-cycle pop credit.
- push = in_valid & in_ready & ~redirect_valid.
- Load-use hazard: hazard = lu_valid & (lu_rd != 0) & ((out_rs1 == lu_rd) | (out_rs2 == lu_rd)).
- out_valid = (count != 0) & ~hazard. out_* always drive the head entry, which is stable whenever count != 0.
- issue (pop) = out_valid & ~mem_stall & ~redirect_valid.
- While mem_stall=1 the head stays presented and is not popped. It pops on the first cycle mem_stall=0.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full is impossible because in_ready=0.
- Latency: a push is visible on out_* the next cycle at the earliest (1-cycle minimum, queue empty).
- Load tracking:
  - On issue of a packet with is_load & need_to_wb & rd != 0: lu_valid<=1, lu_rd<=rd.
  - lu_valid clears on the first cycle with lu_valid=1 & mem_stall=0, i.e. the load's final mem cycle.
  - Result: exactly one bubble minimum after a non-stalling load to a dependent head.
  - A load issuing while lu_valid clears reloads lu_valid (set wins).
- Redirect: redirect_valid=1 sets count=0, pointers=0 and lu_valid=0 next cycle. A same-cycle push is dropped and a same-cycle pop is suppressed. The redirecting instruction has already issued.
- Perf counters:
  - perf_issue_cnt +1 per issue; wraps at 2^64.
  - perf_bubble_cnt +1 per cycle with count!=0 & hazard; saturates at 0xFFFF_FFFF.
  - Neither counter is cleared by redirect.
- Reset mid-operation: all state returns to reset values next edge and in-flight packets are lost.

Optional Feature:
- Macro: ISSUE_BUFFER_BYPASS_EN.
- Defined: when count==0, in_valid=1 and no hazard against in_rs1/in_rs2, the input packet drives out_* combinationally with out_valid=1.
  - If mem_stall=0 it issues that cycle without being written.
  - If mem_stall=1 it is written and remains head.
- Undefined: minimum latency is 1 cycle and there is no input-to-output combinational path.

Test Plan:
- Push 4 packets (pc 0x80000000..0x8000000C) with mem_stall=0 -> issued in order on consecutive cycles from cycle 1; perf_issue_cnt=4.
- Push 5 packets back-to-back, mem_stall=1 for 10 cycles -> in_ready=0 after 4 accepted; head pc 0x80000000 stable all 10 cycles; drains in order after release.
- Issue load rd=5, next packet rs1=5, mem_stall=0 -> exactly one cycle out_valid=0, then the dependent issues; perf_bubble_cnt=1. Repeat with rd=0 -> no bubble.
- Load rd=7 followed by mem_stall=1 for 3 cycles, dependent rs2=7 queued -> dependent issues on the cycle after mem_stall falls.
- 3 packets queued, assert redirect_valid with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; the dropped packet never appears.
- With ISSUE_BUFFER_BYPASS_EN, empty queue, in_valid=1 pc 0x80000100 -> out_valid=1 same cycle, out_pc=0x80000100; without the macro -> appears next cycle.
